// File: rtl/spi_master.sv
// Mode-0 SPI initiator: MSB first, fixed DATA_W-bit frames, one frame per o_ss_n assertion, o_sclk divided from i_clk.
// Optional macro SPI_MASTER_LOOPBACK_EN adds i_loopback, which makes the receiver sample o_mosi instead of i_miso.
module spi_master #(
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_sclk,
    output logic              o_ss_n,
    output logic              o_mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              i_loopback,
`endif
    input  logic              i_miso
);

    localparam int MAX_CNT = (CS_SETUP > CS_IDLE) ?
                             ((CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV) :
                             ((CS_IDLE > CLK_DIV) ? CS_IDLE : CLK_DIV);
    localparam int CNT_W = $clog2(MAX_CNT + 1);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic              w_phaseEnd;
    logic              w_lastBit;
    logic              w_sample;

    assign o_ready   = (r_state == S_IDLE);
    assign o_busy    = (r_state != S_IDLE);
    assign w_lastBit = (r_bitCnt == BIT_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
    logic r_loopback;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_loopback <= 1'b0;
        end else if (o_ready && i_valid) begin
            r_loopback <= i_loopback;
        end
    end

    assign w_sample = r_loopback ? o_mosi : i_miso;
`else
    assign w_sample = i_miso;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // One shared phase counter times setup, each o_sclk half-period, hold and the idle gap.
    always_comb begin
        w_phaseEnd  = 1'b0;
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_valid) w_nextState = S_SETUP;
            end
            S_SETUP: begin
                w_phaseEnd = (r_cnt == SETUP_LAST);
                if (w_phaseEnd) w_nextState = S_SHIFT;
            end
            S_SHIFT: begin
                w_phaseEnd = (r_cnt == DIV_LAST);
                if (w_phaseEnd && o_sclk && w_lastBit) w_nextState = S_HOLD;
            end
            S_HOLD: begin
                w_phaseEnd = (r_cnt == DIV_LAST);
                if (w_phaseEnd) w_nextState = S_GAP;
            end
            S_GAP: begin
                w_phaseEnd = (r_cnt == IDLE_LAST);
                if (w_phaseEnd) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_phaseEnd) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx      <= '0;
            r_rx      <= '0;
            r_bitCnt  <= '0;
            o_rx_data <= '0;
            o_done    <= 1'b0;
            o_sclk    <= 1'b0;
            o_ss_n    <= 1'b1;
            o_mosi    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_tx     <= i_tx_data;
                        r_rx     <= '0;
                        r_bitCnt <= '0;
                        o_ss_n   <= 1'b0;
                        o_sclk   <= 1'b0;
                        o_mosi   <= i_tx_data[DATA_W-1];
                    end
                end
                S_SHIFT: begin
                    if (w_phaseEnd) begin
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                            r_rx   <= {r_rx[DATA_W-2:0], w_sample};
                        end else begin
                            // MOSI only moves on the falling edge so it is stable when the slave samples.
                            o_sclk <= 1'b0;
                            if (w_lastBit) begin
                                o_mosi <= 1'b0;
                            end else begin
                                o_mosi   <= r_tx[DATA_W-2];
                                r_tx     <= {r_tx[DATA_W-2:0], 1'b0};
                                r_bitCnt <= r_bitCnt + BIT_W'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_phaseEnd) begin
                        o_ss_n    <= 1'b1;
                        o_rx_data <= r_rx;
                        o_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: instance 0 runs CLK_DIV=2, instance 1 runs CLK_DIV=1, each with a Mode-0 slave model.
// Expected frames are queued when stimulus is applied and popped on o_done.
module tb_spi_master;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] slv;
        logic [31:0] rx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid [2];
    logic        ready [2];
    logic        busy  [2];
    logic        done  [2];
    logic        sclk  [2];
    logic        ssn   [2];
    logic        mosi  [2];
    logic        miso  [2];
    logic [31:0] txd   [2];
    logic [31:0] rxd   [2];
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        loop  [2];
`endif

    exp_t        expQ [2][$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          planned [2];
    int          doneCnt [2];
    int          slvBits [2];
    logic [31:0] slvTx [2];
    logic [31:0] slvRx [2];
    int          lowCnt [2];
    int          highCnt [2];
    int          acceptCyc [2];
    int          lastDone [2];
    int          lastRise [2];
    int          perErr [2];
    logic        haveDone [2];
    logic        prevSs [2];
    logic        prevSclk [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gInst
        localparam int DIV = (g == 0) ? 2 : 1;
        localparam int EXP_LOW = 2 + 65 * DIV;

        spi_master #(
            .DATA_W(32), .CLK_DIV(DIV), .CS_SETUP(2), .CS_IDLE(4)
        ) uDut (
            .i_clk(clk),
            .i_rst_n(rst_n),
            .i_valid(valid[g]),
            .o_ready(ready[g]),
            .i_tx_data(txd[g]),
            .o_busy(busy[g]),
            .o_done(done[g]),
            .o_rx_data(rxd[g]),
            .o_sclk(sclk[g]),
            .o_ss_n(ssn[g]),
            .o_mosi(mosi[g]),
`ifdef SPI_MASTER_LOOPBACK_EN
            .i_loopback(loop[g]),
`endif
            .i_miso(miso[g])
        );

        // Slave model plus frame monitor, all sampled mid-cycle on the falling i_clk edge.
        always @(negedge clk) begin : mon
            exp_t e;
            if (!rst_n) begin
                prevSs[g]   = 1'b1;
                prevSclk[g] = 1'b0;
                haveDone[g] = 1'b0;
                lowCnt[g]   = 0;
                highCnt[g]  = 0;
                perErr[g]   = 0;
                lastRise[g] = -1;
                slvBits[g]  = 0;
                miso[g]     = 1'b0;
            end else begin
                if (valid[g] && ready[g]) begin
                    acceptCyc[g] = cyc;
                    if (haveDone[g]) checkOutput("accept_after_gap", 32'((cyc - lastDone[g]) >= 4), 32'd1);
                end
                if (prevSs[g] && !ssn[g]) begin
                    if (haveDone[g]) checkOutput("ss_high_gap", 32'(highCnt[g] >= 4), 32'd1);
                    lowCnt[g]   = 0;
                    perErr[g]   = 0;
                    lastRise[g] = -1;
                    slvBits[g]  = 0;
                    slvRx[g]    = '0;
                    slvTx[g]    = (expQ[g].size() != 0) ? expQ[g][0].slv : 32'h0;
                    miso[g]     = slvTx[g][31];
                end
                if (!prevSs[g] && ssn[g]) highCnt[g] = 0;
                if (!ssn[g]) lowCnt[g]++;
                else highCnt[g]++;
                if (!prevSclk[g] && sclk[g] && !ssn[g]) begin
                    if (lastRise[g] >= 0 && (cyc - lastRise[g]) != 2 * DIV) perErr[g]++;
                    lastRise[g] = cyc;
                    slvRx[g]    = {slvRx[g][30:0], mosi[g]};
                    slvBits[g]++;
                end
                if (prevSclk[g] && !sclk[g] && !ssn[g]) begin
                    slvTx[g] = {slvTx[g][30:0], 1'b0};
                    miso[g]  = slvTx[g][31];
                end
                if (done[g]) begin
                    doneCnt[g]++;
                    checkOutput("frame_expected", 32'(expQ[g].size() != 0), 32'd1);
                    if (expQ[g].size() != 0) begin
                        e = expQ[g].pop_front();
                        checkOutput("rx_data", rxd[g], e.rx);
                        checkOutput("mosi_word", slvRx[g], e.tx);
                        checkOutput("sclk_rises", slvBits[g], 32'd32);
                        checkOutput("ss_low_cycles", lowCnt[g], EXP_LOW);
                        checkOutput("done_latency", cyc - acceptCyc[g], EXP_LOW + 1);
                        checkOutput("sclk_period_errs", perErr[g], 32'd0);
                    end
                    checkOutput("ss_high_at_done", {31'd0, ssn[g]}, 32'd1);
                    haveDone[g] = 1'b1;
                    lastDone[g] = cyc;
                end
                prevSs[g]   = ssn[g];
                prevSclk[g] = sclk[g];
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input int g, input logic [31:0] tx, input logic [31:0] slv,
                                 input logic [31:0] rx, input bit keep);
        exp_t e;
        int n;
        e.tx = tx;
        e.slv = slv;
        e.rx = rx;
        expQ[g].push_back(e);
        planned[g]++;
        txd[g] = tx;
        valid[g] = 1'b1;
        n = 0;
        while (!ready[g] && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("accept_wait", 32'(n < 1000), 32'd1);
        @(posedge clk); #1;
        if (!keep) valid[g] = 1'b0;
    endtask

    task automatic waitBits(input int g, input int bits);
        int n;
        n = 0;
        while (slvBits[g] < bits && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("bits_reached", 32'(slvBits[g] >= bits), 32'd1);
    endtask

    task automatic drain(input int g);
        int n;
        n = 0;
        while (expQ[g].size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain", expQ[g].size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            txd[i] = '0;
            planned[i] = 0;
            doneCnt[i] = 0;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop[i] = 1'b0;
`endif
        end
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_ss_n", {31'd0, ssn[0]}, 32'd1);
        checkOutput("rst_sclk", {31'd0, sclk[0]}, 32'd0);
        checkOutput("rst_mosi", {31'd0, mosi[0]}, 32'd0);
        checkOutput("rst_rx_data", rxd[0], 32'd0);
        checkOutput("rst_done", {31'd0, done[0]}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy[0]}, 32'd0);
        checkOutput("rst_ready", {31'd0, ready[0]}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic frame");
        applyStimulus(0, 32'hA5C3_0F81, 32'h1234_5678, 32'h1234_5678, 1'b0);
        drain(0);

        $display("[TB] back-to-back with i_valid held");
        applyStimulus(0, 32'h0BAD_F00D, 32'hCAFE_0001, 32'hCAFE_0001, 1'b1);
        applyStimulus(0, 32'h7E57_1234, 32'h8001_7FFE, 32'h8001_7FFE, 1'b0);
        drain(0);

        $display("[TB] start request while busy");
        applyStimulus(0, 32'h3C3C_9669, 32'h6996_C3C3, 32'h6996_C3C3, 1'b0);
        waitBits(0, 8);
        checkOutput("busy_mid_frame", {31'd0, busy[0]}, 32'd1);
        txd[0] = 32'hFFFF_FFFF;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        drain(0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 32'h1357_9BDF, 32'h2468_ACE0, 32'h2468_ACE0, 1'b0);
        waitBits(0, 11);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ss_n", {31'd0, ssn[0]}, 32'd1);
        checkOutput("abort_sclk", {31'd0, sclk[0]}, 32'd0);
        checkOutput("abort_rx_data", rxd[0], 32'd0);
        checkOutput("abort_done", {31'd0, done[0]}, 32'd0);
        expQ[0].delete();
        planned[0]--;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 32'hC001_D00D, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 1'b0);
        drain(0);

        $display("[TB] minimum divider");
        applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0);
        applyStimulus(1, 32'h5555_5555, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0);
        drain(1);

`ifdef SPI_MASTER_LOOPBACK_EN
        $display("[TB] loopback");
        loop[0] = 1'b1;
        applyStimulus(0, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
        loop[0] = 1'b0;
        drain(0);
`endif

        repeat (20) @(posedge clk);
        #1;
        checkOutput("frame_count0", doneCnt[0], planned[0]);
        checkOutput("frame_count1", doneCnt[1], planned[1]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-clock SPI initiator for the team's SPI peripheral slaves.
- Mode 0 (CPOL=0, CPHA=0), MSB first, fixed DATA_W-bit frames, one frame per chip-select assertion.
- Generates o_sclk by dividing i_clk.
- Sits on the SoC peripheral bus side: software loads a word, starts a transfer, and reads the received word back after o_done.

Parameters:
- DATA_W, 32, frame length in bits (must be ≥2).
- CLK_DIV, 4, i_clk cycles per o_sclk half-period (≥1).
- CS_SETUP, 2, i_clk cycles with o_ss_n low and o_sclk low before the first bit's low phase (≥2, so the slave can detect the ss_n fall and preload its transmit register).
- CS_IDLE, 4, minimum i_clk cycles o_ss_n stays high after a frame (≥2, so the slave can latch received and next transmit data).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  reset
- i_valid  in  1  start request
- o_ready  out  1  high in IDLE only; transfer accepted when i_valid && o_ready
- i_tx_data  in  DATA_W  word to send; captured on accept
- o_busy  out  1  high from accept until return to IDLE
- o_done  out  1  one-cycle pulse on frame completion
- o_rx_data  out  DATA_W  last received word; held until next o_done
- o_sclk  out  1  SPI clock, idle low
- o_ss_n  out  1  chip select, active low
- o_mosi  out  1  serial data out
- i_miso  in  1  serial data in; assumed synchronous to o_sclk at these divider ratios

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_ss_n=1, o_sclk=0, o_mosi=0, o_rx_data=0, o_done=0, o_busy=0, o_ready=1, state IDLE.
- Reset asserted mid-frame aborts immediately: o_ss_n rises, there is no o_done, and o_rx_data is cleared.
- All outputs are registered except o_ready/o_busy, which decode from state.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - o_ss_n=1, o_sclk=0.
  - On accept (cycle T): tx shift register <= i_tx_data, bit counter <= 0, go to SETUP.
  - i_valid is ignored in every other state.
- SETUP:
  - From T+1: o_ss_n=0, o_mosi=tx[DATA_W-1], o_sclk=0.
  - Lasts CS_SETUP cycles, then SHIFT.
- SHIFT: each bit is CLK_DIV cycles with o_sclk=0, then CLK_DIV cycles with o_sclk=1.
  - Rising edge: at the i_clk edge driving o_sclk 0->1, rx shift <= {rx shift[DATA_W-2:0], i_miso}.
  - Falling edge: at the i_clk edge driving o_sclk 1->0, o_mosi <= next tx bit, except after bit DATA_W-1, where o_mosi <= 0.
  - o_mosi is therefore stable across every rising edge.
  - After the high phase of bit DATA_W-1: o_sclk=0, go to HOLD.
- HOLD: CLK_DIV cycles with o_ss_n=0, o_sclk=0.
- Completion: on leaving HOLD, o_ss_n <= 1, o_rx_data <= rx shift, and o_done=1 for exactly that one cycle (first cycle of GAP).
- GAP: CS_IDLE cycles with o_ss_n=1, o_ready=0, o_busy=1, then IDLE.
- Frame timing:
  - o_ss_n low for exactly CS_SETUP + (2*DATA_W+1)*CLK_DIV cycles.
  - Accept-to-o_done latency = 1 + that count.
  - Accept-to-next-accept minimum = latency + CS_IDLE.
- Counters: the divider counter wraps at CLK_DIV-1; the bit counter is $clog2(DATA_W) bits and is not wrapped during a frame.
- i_tx_data changes after accept have no effect on the frame in flight.

Optional Feature:
- Macro: SPI_MASTER_LOOPBACK_EN.
- When defined:
  - Adds input port i_loopback (1 bit), sampled on accept and held for the frame.
  - If set, the rising-edge sample uses o_mosi instead of i_miso, so o_rx_data equals the transmitted word.
  - o_sclk, o_ss_n and o_mosi still toggle normally.
- When undefined: no extra port; the sample always uses i_miso.

Test Plan:
- Reset values and basic frame:
  - Check reset values, then CLK_DIV=2, CS_SETUP=2.
  - Accept i_tx_data=0xA5C3_0F81 with a slave model returning 0x1234_5678.
  - Required: o_mosi sampled on 32 rising edges = 0xA5C3_0F81; o_rx_data=0x1234_5678; o_ss_n low exactly 132 cycles; o_done one cycle at accept+133.
- Back-to-back requests:
  - Hold i_valid high continuously.
  - Required: second accept no earlier than CS_IDLE (4) cycles after o_done; o_ss_n high ≥4 cycles between frames; both words transferred correctly.
- Ignored start while busy:
  - Pulse i_valid with 0xFFFF_FFFF mid-frame.
  - Required: ignored; the in-flight frame's data is unchanged; no extra frame.
- Reset mid-frame:
  - Assert i_rst_n low after bit 10.
  - Required: o_ss_n=1, o_sclk=0, o_rx_data=0 asynchronously; no o_done; next frame after reset is correct.
- Minimum divider:
  - CLK_DIV=1, all-ones TX and all-zeros RX, then alternating 0x5555_5555.
  - Required: o_sclk period 2 cycles; data exact; o_ss_n low 2+65=67 cycles.
- Loopback (SPI_MASTER_LOOPBACK_EN defined):
  - i_loopback=1, TX 0xDEAD_BEEF, i_miso forced 0.
  - Required: o_rx_data=0xDEAD_BEEF.
